bitty_ctrl_fsm: RTL and testbench
=================================

Name: bitty_ctrl_fsm

Overview:
Multi-cycle control unit for the 16-bit datapath. It sequences fetch, decode, execute and writeback over the shared enable-gated 16-bit registers: instruction register, S operand register, C result register and an 8-entry register file. It drives only enables and mux/ALU selects; the registers themselves hold data and reset to their own starting values. It sits between instruction memory (valid/ready handshake) and the datapath.

Parameters:
DATA_W, 16, instruction and immediate output width
NUM_REGS, 8, register-file entries; en_rf width
SEL_W, 3, register select width (log2 NUM_REGS)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
run  in  1  level; 1 = keep executing, 0 = stop after current instruction
instr_valid  in  1  instruction memory has instr
instr_ready  out  1  controller accepts instr this cycle
instr  in  16  instruction word
en_i  out  1  instruction register enable
en_s  out  1  S register enable
en_c  out  1  C register enable
en_rf  out  8  one-hot register-file write enables
mux_sel  out  3  register-file read select
imm_sel  out  1  1 = ALU B operand is imm_out
imm_out  out  16  zero-extended immediate
alu_sel  out  3  ALU operation
done  out  1  one-cycle pulse per retired instruction
halted  out  1  high in HALT
retired_cnt  out  16  retired-instruction count

Behaviour:
- Instruction fields: rx=instr[15:13], ry=instr[12:10], alu_op=instr[4:2], fmt=instr[1:0]. imm=instr[12:5], zero-extended to 16.
- fmt 00 is R-type (rx op ry -> rx). fmt 01 is I-type (rx op imm -> rx). fmt 10 is NOP (no writeback). fmt 11 is HALT.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- Reset: state=IDLE, internal instruction copy=0, retired_cnt=0.
  - While reset=1, all enables, instr_ready, done, halted and imm_sel are forced 0, regardless of state.
  - mux_sel, alu_sel and imm_out are 0 while reset=1.
- IDLE: all enables 0. run=1 -> FETCH.
- FETCH: instr_ready=1.
  - instr_valid=1: en_i=1 in the same cycle, instr is captured internally, next state DECODE.
  - instr_valid=0: remain in FETCH with no enables, indefinitely.
- DECODE: decodes the captured copy.
  - fmt 11: no enables, next state HALT.
  - Otherwise: mux_sel=rx, en_s=1, next state EXEC.
- EXEC: alu_sel=alu_op, en_c=1, next state WB.
  - R-type and NOP: mux_sel=ry, imm_sel=0.
  - I-type: imm_sel=1, imm_out=imm.
- WB:
  - fmt 00/01: en_rf = one-hot of rx.
  - fmt 10: en_rf=0.
  - done=1; retired_cnt increments, wrapping 0xFFFF->0x0000.
  - Next state FETCH if run=1, else IDLE.
- HALT: halted=1, all enables 0. HALT is left only via reset. HALT does not pulse done or increment retired_cnt.
- Latency: 4 cycles per instruction with instr_valid held high (FETCH, DECODE, EXEC, WB). done is asserted in cycle 4.
- Exclusivity: en_i, en_s, en_c and any en_rf bit are mutually exclusive in every cycle. At most one en_rf bit is high.
- Outputs are Moore decodes of state plus the captured instruction. The exception is en_i, which is FETCH AND instr_valid.
- run deasserted mid-instruction: the current instruction completes through WB, then the controller goes to IDLE.
- rx=ry is legal. rx=0 is writable (no hardwired zero).
- Reset mid-instruction: enables drop in the reset cycle and the controller is in IDLE on the next edge. A partially executed instruction is discarded without writeback.
- mux_sel and alu_sel are don't-care when not listed above; they are driven 0.

Test Plan:
1. Reset, run=1, instr_valid=1, instr=0x2401 (rx=1, ry=1, alu_op=0, fmt=01, imm=0x20) -> en_i at cycle 1; en_s with mux_sel=1 at cycle 2; en_c with imm_sel=1 and imm_out=0x0020 at cycle 3; en_rf=0x02 and done=1 at cycle 4; retired_cnt=1.
2. R-type instr=0xE80C (rx=7, ry=2, alu_op=3, fmt=00) -> EXEC shows mux_sel=2, alu_sel=3, imm_sel=0; WB shows en_rf=0x80.
3. instr_valid held 0 for 5 cycles in FETCH -> instr_ready=1 and all enables 0 throughout; when valid rises, en_i=1 in that cycle.
4. fmt 10 NOP, then fmt 11 HALT -> NOP gives done=1 with en_rf=0x00; HALT gives halted=1 two cycles after fetch, no further enables or done; retired_cnt stays at 1 until reset.
5. reset asserted during EXEC -> en_c=0 in that cycle, state IDLE next cycle, retired_cnt=0, no en_rf pulse.
6. Preload retired_cnt to 0xFFFF by running 65535 NOPs, then one more -> retired_cnt=0x0000. run dropped during DECODE -> instruction completes with done=1, then IDLE with instr_ready=0.

Source files
------------

// File: rtl/bitty_ctrl_fsm.sv
// bitty_ctrl_fsm: multi-cycle control unit for the 16-bit bitty datapath.
// Sequences FETCH/DECODE/EXEC/WB and drives register enables and selects.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   run                 1 = keep executing, 0 = stop after current instr
//   instr_valid/ready   instruction memory handshake, instr = word
//   en_i, en_s, en_c    instruction / S / C register enables
//   en_rf               one-hot register-file write enables
//   mux_sel             register-file read select
//   imm_sel, imm_out    ALU B operand select and zero-extended immediate
//   alu_sel             ALU operation
//   done                one-cycle pulse per retired instruction
//   halted              high in HALT
//   retired_cnt         retired-instruction count (wraps)
module bitty_ctrl_fsm #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [DATA_W-1:0]   instr,
    output logic                en_i,
    output logic                en_s,
    output logic                en_c,
    output logic [NUM_REGS-1:0] en_rf,
    output logic [SEL_W-1:0]    mux_sel,
    output logic                imm_sel,
    output logic [DATA_W-1:0]   imm_out,
    output logic [2:0]          alu_sel,
    output logic                done,
    output logic                halted,
    output logic [DATA_W-1:0]   retired_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] retired_q;

    logic [SEL_W-1:0]    rx;
    logic [SEL_W-1:0]    ry;
    logic [2:0]          alu_op;
    logic [1:0]          fmt;
    logic [DATA_W-1:0]   imm;
    logic [NUM_REGS-1:0] rx_onehot;

    assign rx        = ir_q[15:13];
    assign ry        = ir_q[12:10];
    assign alu_op    = ir_q[4:2];
    assign fmt       = ir_q[1:0];
    assign imm       = {{(DATA_W-8){1'b0}}, ir_q[12:5]};
    assign rx_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << rx;

    assign retired_cnt = retired_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (en_i) begin
                ir_q <= instr;
            end
            // Count only on the retiring cycle so the value holds otherwise.
            if (done) begin
                retired_q <= retired_q + DATA_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        en_i        = 1'b0;
        en_s        = 1'b0;
        en_c        = 1'b0;
        en_rf       = '0;
        mux_sel     = '0;
        imm_sel     = 1'b0;
        imm_out     = '0;
        alu_sel     = '0;
        done        = 1'b0;
        halted      = 1'b0;
        // Reset overrides every state so nothing is enabled in that cycle.
        if (!reset) begin
            unique case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    instr_ready = 1'b1;
                    if (instr_valid) begin
                        en_i    = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (fmt == 2'b11) begin
                        state_d = S_HALT;
                    end else begin
                        mux_sel = rx;
                        en_s    = 1'b1;
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_sel = alu_op;
                    en_c    = 1'b1;
                    if (fmt == 2'b01) begin
                        imm_sel = 1'b1;
                        imm_out = imm;
                    end else begin
                        mux_sel = ry;
                    end
                    state_d = S_WB;
                end
                S_WB: begin
                    // NOP retires without touching the register file.
                    if (!fmt[1]) begin
                        en_rf = rx_onehot;
                    end
                    done    = 1'b1;
                    state_d = run ? S_FETCH : S_IDLE;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitty_ctrl_fsm.sv
// tb_bitty_ctrl_fsm: scoreboard bench for bitty_ctrl_fsm.
// Per-cycle expected output vectors are queued and compared at negedge.
module tb_bitty_ctrl_fsm;

    localparam int PH_IDLE  = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_DEC   = 2;
    localparam int PH_EXEC  = 3;
    localparam int PH_WB    = 4;
    localparam int PH_HALT  = 5;

    typedef logic [52:0] vec_t;

    logic        clk;
    logic        reset;
    logic        run;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        en_i;
    logic        en_s;
    logic        en_c;
    logic [7:0]  en_rf;
    logic [2:0]  mux_sel;
    logic        imm_sel;
    logic [15:0] imm_out;
    logic [2:0]  alu_sel;
    logic        done;
    logic        halted;
    logic [15:0] retired_cnt;

    int          checks;
    int          errors;
    logic [15:0] m_cnt;
    vec_t        sb[$];

    bitty_ctrl_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .en_i        (en_i),
        .en_s        (en_s),
        .en_c        (en_c),
        .en_rf       (en_rf),
        .mux_sel     (mux_sel),
        .imm_sel     (imm_sel),
        .imm_out     (imm_out),
        .alu_sel     (alu_sel),
        .done        (done),
        .halted      (halted),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic vec_t pack_out();
        return {instr_ready, en_i, en_s, en_c, en_rf, mux_sel, imm_sel,
                imm_out, alu_sel, done, halted, retired_cnt};
    endfunction

    function automatic vec_t model(input int ph, input logic [15:0] ir,
                                   input logic valid, input logic [15:0] cnt);
        logic       rdy, ei, es, ec, isel, dn, hl;
        logic [7:0] rf;
        logic [2:0] ms, as;
        logic [15:0] im;
        logic [2:0] rx, ry, op;
        logic [1:0] fmt;
        rdy = 0; ei = 0; es = 0; ec = 0; isel = 0; dn = 0; hl = 0;
        rf = 0; ms = 0; as = 0; im = 0;
        rx = ir[15:13]; ry = ir[12:10]; op = ir[4:2]; fmt = ir[1:0];
        case (ph)
            PH_FETCH: begin rdy = 1; ei = valid; end
            PH_DEC: if (fmt != 2'b11) begin ms = rx; es = 1; end
            PH_EXEC: begin
                ec = 1; as = op;
                if (fmt == 2'b01) begin isel = 1; im = {8'h00, ir[12:5]}; end
                else ms = ry;
            end
            PH_WB: begin
                if (fmt == 2'b00 || fmt == 2'b01) rf = 8'(1) << rx;
                dn = 1;
            end
            PH_HALT: hl = 1;
            default: ;
        endcase
        return {rdy, ei, es, ec, rf, ms, isel, im, as, dn, hl, cnt};
    endfunction

    // One instruction from FETCH through WB; caller leaves DUT in FETCH.
    task automatic exec_instr(input logic [15:0] ins, input int waits,
                              input bit drop_run, input string tag);
        vec_t e, a;
        int   n;
        n = waits + 4;
        for (int k = 0; k < n; k++) begin
            instr       = ins;
            instr_valid = (k == waits);
            if (drop_run && k == waits + 1) run = 1'b0;
            if (k <= waits) e = model(PH_FETCH, ins, instr_valid, m_cnt);
            else            e = model(PH_FETCH + k - waits, ins, 1'b0, m_cnt);
            sb.push_back(e);
            @(negedge clk);
            a = pack_out();
            e = sb.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s cyc%0d act=%h exp=%h", tag, k, a, e);
            end
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        m_cnt++;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; instr_valid = 1'b0; instr = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; run = 1'b1; m_cnt = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        vec_t a, e;
        reset = 1'b1; run = 1'b1; instr_valid = 1'b1; instr = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        m_cnt = '0;
        @(negedge clk);
        a = pack_out(); e = '0; checks++;
        if (a !== e) begin
            errors++; $display("FAIL reset_outputs act=%h exp=%h", a, e);
        end
        @(posedge clk); #1;
        reset = 1'b0; instr_valid = 1'b0;
        sb.push_back(model(PH_IDLE, 16'h0, 1'b0, m_cnt));
        @(negedge clk);
        a = pack_out(); e = sb.pop_front(); checks++;
        if (a !== e) begin
            errors++; $display("FAIL reset_idle act=%h exp=%h", a, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_itype();
        exec_instr(16'h2401, 0, 1'b0, "itype");
        @(negedge clk);
        checks++;
        if (retired_cnt !== 16'd1) begin
            errors++;
            $display("FAIL itype_cnt act=%h exp=%h", retired_cnt, 16'd1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        exec_instr(16'hE80C, 0, 1'b0, "rtype");
    endtask

    task automatic test_stall();
        exec_instr(16'h4C05, 5, 1'b0, "stall");
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom);
            w[1:0] = 2'(i % 3);
            exec_instr(w, i % 2, 1'b0, "b2b");
        end
    endtask

    task automatic test_nop_halt();
        vec_t a, e;
        do_reset();
        exec_instr(16'h0002, 0, 1'b0, "nop");
        for (int k = 0; k < 8; k++) begin
            instr = 16'h0003; instr_valid = (k == 0);
            if (k == 0)      e = model(PH_FETCH, 16'h0003, 1'b1, m_cnt);
            else if (k == 1) e = model(PH_DEC, 16'h0003, 1'b0, m_cnt);
            else             e = model(PH_HALT, 16'h0003, 1'b0, m_cnt);
            if (k >= 1) instr_valid = 1'b1;
            sb.push_back(e);
            @(negedge clk);
            a = pack_out(); e = sb.pop_front(); checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL halt cyc%0d act=%h exp=%h", k, a, e);
            end
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        vec_t a, e;
        do_reset();
        exec_instr(16'h0000, 0, 1'b0, "pre_mid");
        instr = 16'h2401; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        a = pack_out(); e = {37'b0, m_cnt}; checks++;
        if (a !== e) begin
            errors++; $display("FAIL rst_exec act=%h exp=%h", a, e);
        end
        @(posedge clk); #1;
        reset = 1'b0; run = 1'b0; m_cnt = '0;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(model(PH_IDLE, 16'h0, 1'b0, m_cnt));
            @(negedge clk);
            a = pack_out(); e = sb.pop_front(); checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL rst_idle cyc%0d act=%h exp=%h", k, a, e);
            end
            @(posedge clk); #1;
        end
        run = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_wrap_stop();
        vec_t a, e;
        // Preload the count near its top instead of retiring 65534 NOPs.
        force dut.retired_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.retired_q;
        m_cnt = 16'hFFFE;
        exec_instr(16'h0002, 0, 1'b0, "wrap_ffff");
        exec_instr(16'h0002, 0, 1'b1, "wrap_stop");
        for (int k = 0; k < 3; k++) begin
            sb.push_back(model(PH_IDLE, 16'h0, 1'b0, m_cnt));
            @(negedge clk);
            a = pack_out(); e = sb.pop_front(); checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL stop_idle cyc%0d act=%h exp=%h", k, a, e);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (retired_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_cnt act=%h exp=%h", retired_cnt, 16'h0000);
        end
    endtask

    initial begin
        checks = 0; errors = 0; m_cnt = '0;
        reset = 1'b1; run = 1'b0; instr_valid = 1'b0; instr = '0;
        test_reset();
        test_itype();
        test_rtype();
        test_stall();
        test_back_to_back();
        test_nop_halt();
        test_reset_mid();
        test_wrap_stop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
